branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//   Fully associative branch target buffer (BTB) for the fetch stage.
//   Each cycle it looks up the fetch PC. On a hit it predicts taken and supplies the stored target.
//   On a miss it predicts not-taken and supplies PC+4.
//   Execute/writeback installs or refreshes entries through an update port; victims are chosen by true LRU.
// PARAMETERS
//   ENTRIES  4   number of BTB entries (>=2, power of two)
//   XLEN     32  address width
// PORTS
//   clk            in   1     clock; all state updates on rising edge
//   rst_n          in   1     asynchronous active-low reset
//   fetch_pc       in   XLEN  PC being fetched (lookup key)
//   branch_addr    out  XLEN  predicted next PC
//   prediction     out  1     1 = BTB hit / predict taken
//   update_en      in   1     write request for the current cycle
//   update_pc      in   XLEN  branch PC to install/refresh
//   update_target  in   XLEN  resolved taken target for update_pc
// BEHAVIOUR
//   Storage per entry: valid bit, tag = full XLEN-bit PC, target (XLEN), LRU age (log2(ENTRIES) bits).
//   Reset (async, rst_n=0):
//   - all valid bits cleared; targets and tags need no reset;
//   - entry i age = i, a distinct permutation.
//   Lookup is purely combinational, zero latency:
//   - hit = any valid entry with tag == fetch_pc; at most one entry can match;
//   - hit:  prediction=1, branch_addr=matching target;
//   - miss: prediction=0, branch_addr=fetch_pc+4, mod 2^XLEN so 0xFFFFFFFC wraps to 0.
//   - During/after reset: prediction=0 and branch_addr=fetch_pc+4.
//   Lookups never modify LRU state.
//   Update, on a clock edge with update_en=1:
//   - if a valid entry's tag == update_pc, overwrite its target (no duplicate is created);
//   - else, if any entry is invalid, allocate the lowest-index invalid entry;
//   - else replace the LRU entry, i.e. the one with age ENTRIES-1;
//   - in all three cases set valid=1, tag=update_pc, target=update_target.
//   LRU maintenance on every update:
//   - the written entry's age becomes 0 (MRU);
//   - every entry whose age was below the written entry's old age increments by 1;
//   - all other ages are unchanged;
//   - ages therefore always remain a permutation of 0..ENTRIES-1.
//   update_en=0: no state change.
//   Same-cycle update and lookup of the same PC:
//   - lookup returns pre-edge contents (miss, or the old target);
//   - the new value is visible in the cycle after the edge.
//   Write-to-read latency: 1 cycle.
//   No handshake and no stall; an update is accepted every cycle.
//   Reset asserted mid-operation invalidates all entries immediately; any in-flight update is dropped.
// TESTING
//   Run all scenarios with ENTRIES=4, sequentially after reset release.
//   1 Empty lookup: fetch_pc=0x1000 -> prediction=0, branch_addr=0x1004.
//   2 Install: update 0x1000->0x2000, then fetch 0x1000 -> prediction=1, branch_addr=0x2000.
//     In the update cycle itself, fetch 0x1000 -> prediction=0, branch_addr=0x1004.
//   3 Second entry and miss:
//     update 0x3000->0x4000; fetch 0x3000 -> 1 / 0x4000; fetch 0x5000 -> 0 / 0x5004.
//   4 Overwrite: update 0x1000->0x2100; fetch 0x1000 -> 1 / 0x2100, with no second entry consumed.
//   5 LRU eviction: update 0x6000..0x6010 step 4, targets 0x7000.. step 4.
//     Evictions occur in order 0x3000, 0x1000, 0x6000.
//     Fetch 0x6000 -> 0 / 0x6004; fetch 0x6004 -> 1 / 0x7004; fetch 0x6010 -> 1 / 0x7010.
//     Fetch 0x3000 -> 0 / 0x3004.
//   6 Async reset: assert rst_n=0 between clock edges.
//     prediction drops to 0 without waiting for a clock; all prior entries miss after release.
//     Also check fetch_pc=0xFFFFFFFC on a miss -> branch_addr=0x00000000.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-stage BTB interface: lookup request/response plus the execute-side update port.
// The master side is the pipeline. The slave side is the BTB.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] branch_addr;
    logic            prediction;
    logic            update_en;
    logic [XLEN-1:0] update_pc;
    logic [XLEN-1:0] update_target;

    modport master (
        output fetch_pc,
        output update_en,
        output update_pc,
        output update_target,
        input  branch_addr,
        input  prediction
    );

    modport slave (
        input  fetch_pc,
        input  update_en,
        input  update_pc,
        input  update_target,
        output branch_addr,
        output prediction
    );
endinterface

// File: rtl/branch_predictor.sv
// Fully associative branch target buffer with true-LRU replacement.
// Lookup is combinational. Updates land on the rising edge.
module branch_predictor #(
    parameter int ENTRIES = 4,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_predictor_if.slave bp
);
    localparam int AW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_valid;
    logic [XLEN-1:0]    r_tag [ENTRIES];
    logic [XLEN-1:0]    r_tgt [ENTRIES];
    logic [AW-1:0]      r_age [ENTRIES];

    logic            w_hit;
    logic [XLEN-1:0] w_hit_tgt;
    logic            w_match;
    logic [AW-1:0]   w_match_idx;
    logic            w_inv;
    logic [AW-1:0]   w_inv_idx;
    logic [AW-1:0]   w_lru_idx;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_old_age;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_tgt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == bp.fetch_pc)) begin
                w_hit     = 1'b1;
                w_hit_tgt = r_tgt[i];
            end
        end
    end

    assign bp.prediction  = w_hit;
    assign bp.branch_addr = w_hit ? w_hit_tgt : (bp.fetch_pc + XLEN'(4));

    // Descending scan, so the lowest-index invalid entry wins the allocation.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_inv       = 1'b0;
        w_inv_idx   = '0;
        w_lru_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_inv     = 1'b1;
                w_inv_idx = AW'(i);
            end
            if (r_age[i] == AW'(ENTRIES - 1)) begin
                w_lru_idx = AW'(i);
            end
            if (r_valid[i] && (r_tag[i] == bp.update_pc)) begin
                w_match     = 1'b1;
                w_match_idx = AW'(i);
            end
        end
        w_wr_idx  = w_match ? w_match_idx : (w_inv ? w_inv_idx : w_lru_idx);
        w_old_age = r_age[w_wr_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_age[i]   <= AW'(i);
            end
        end else if (bp.update_en) begin
            r_valid[w_wr_idx] <= 1'b1;
            for (int i = 0; i < ENTRIES; i++) begin
                if (AW'(i) == w_wr_idx) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < w_old_age) begin
                    r_age[i] <= r_age[i] + AW'(1);
                end
            end
        end
    end

    // Tag/target need no reset: an entry is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (bp.update_en) begin
            r_tag[w_wr_idx] <= bp.update_pc;
            r_tgt[w_wr_idx] <= bp.update_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for the BTB: empty lookup, install, overwrite, LRU eviction,
// asynchronous reset and PC+4 wrap.
module tb_branch_predictor;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fails;

    branch_predictor_if #(.XLEN(XLEN)) bp_if ();

    branch_predictor #(.ENTRIES(4), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [XLEN-1:0] pc,
                        input logic exp_pred, input logic [XLEN-1:0] exp_addr);
        bp_if.fetch_pc = pc;
        #1;
        chk({tag, ".pred"}, XLEN'(bp_if.prediction), XLEN'(exp_pred));
        chk({tag, ".addr"}, bp_if.branch_addr, exp_addr);
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
        bp_if.update_en     = 1'b1;
        bp_if.update_pc     = pc;
        bp_if.update_target = tgt;
        @(posedge clk);
        #1;
        bp_if.update_en = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        rst_n               = 1'b0;
        bp_if.fetch_pc      = '0;
        bp_if.update_en     = 1'b0;
        bp_if.update_pc     = '0;
        bp_if.update_target = '0;

        #2;
        look("rst_hold", 32'h0000_1000, 1'b0, 32'h0000_1004);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1 empty lookup
        look("empty", 32'h0000_1000, 1'b0, 32'h0000_1004);

        // 2 install, with the same-cycle lookup still seeing the old contents
        bp_if.update_en     = 1'b1;
        bp_if.update_pc     = 32'h0000_1000;
        bp_if.update_target = 32'h0000_2000;
        look("same_cyc", 32'h0000_1000, 1'b0, 32'h0000_1004);
        @(posedge clk);
        #1;
        bp_if.update_en = 1'b0;
        look("install", 32'h0000_1000, 1'b1, 32'h0000_2000);

        // 3 second entry and a miss
        upd(32'h0000_3000, 32'h0000_4000);
        look("second", 32'h0000_3000, 1'b1, 32'h0000_4000);
        look("miss5k", 32'h0000_5000, 1'b0, 32'h0000_5004);
        look("first_kept", 32'h0000_1000, 1'b1, 32'h0000_2000);

        // 4 overwrite in place
        upd(32'h0000_1000, 32'h0000_2100);
        look("overwrite", 32'h0000_1000, 1'b1, 32'h0000_2100);

        // 5 fill then evict in LRU order 0x3000, 0x1000, 0x6000
        upd(32'h0000_6000, 32'h0000_7000);
        upd(32'h0000_6004, 32'h0000_7004);
        look("pre_evict3k", 32'h0000_3000, 1'b1, 32'h0000_4000);
        upd(32'h0000_6008, 32'h0000_7008);
        look("evict3k", 32'h0000_3000, 1'b0, 32'h0000_3004);
        look("keep1k", 32'h0000_1000, 1'b1, 32'h0000_2100);
        upd(32'h0000_600C, 32'h0000_700C);
        look("evict1k", 32'h0000_1000, 1'b0, 32'h0000_1004);
        look("keep6000", 32'h0000_6000, 1'b1, 32'h0000_7000);
        upd(32'h0000_6010, 32'h0000_7010);
        look("evict6000", 32'h0000_6000, 1'b0, 32'h0000_6004);
        look("hit6004", 32'h0000_6004, 1'b1, 32'h0000_7004);
        look("hit6008", 32'h0000_6008, 1'b1, 32'h0000_7008);
        look("hit600c", 32'h0000_600C, 1'b1, 32'h0000_700C);
        look("hit6010", 32'h0000_6010, 1'b1, 32'h0000_7010);
        look("miss3k", 32'h0000_3000, 1'b0, 32'h0000_3004);

        // 6 async reset between edges, with an update pending across an edge
        bp_if.fetch_pc = 32'h0000_6004;
        #2;
        rst_n               = 1'b0;
        bp_if.update_en     = 1'b1;
        bp_if.update_pc     = 32'h0000_9000;
        bp_if.update_target = 32'h0000_A000;
        look("async_drop", 32'h0000_6004, 1'b0, 32'h0000_6008);
        @(posedge clk);
        #2;
        bp_if.update_en = 1'b0;
        rst_n           = 1'b1;
        @(posedge clk);
        #1;
        look("post_rst6004", 32'h0000_6004, 1'b0, 32'h0000_6008);
        look("post_rst6010", 32'h0000_6010, 1'b0, 32'h0000_6014);
        look("dropped_upd", 32'h0000_9000, 1'b0, 32'h0000_9004);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // table usable again after reset
        upd(32'hFFFF_FFFC, 32'h0000_0100);
        look("wrap_hit", 32'hFFFF_FFFC, 1'b1, 32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
